// File: rtl/hex_disp_scan.sv
// hex_disp_scan: time-multiplexed 8-digit seven-segment driver.
// A frame is 8 slots of CLK_DIV cycles; each slot starts with BLANK_CYC dark
// cycles to suppress ghosting. Digit values are captured once per frame so a
// shift of the upstream register never tears the visible frame.
module hex_disp_scan #(
  parameter int CLK_DIV   = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hex0,
  input  logic [3:0] hex1,
  input  logic [3:0] hex2,
  input  logic [3:0] hex3,
  input  logic [3:0] hex4,
  input  logic [3:0] hex5,
  input  logic [3:0] hex6,
  input  logic [3:0] hex7,
  input  logic [7:0] dp_in,
  input  logic [7:0] dig_en,
  input  logic       lz_blank,
  output logic [7:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [31:0]   r_snap;
  logic          r_primed;

  logic          w_slot_end;
  logic          w_frame_end;
  logic [3:0]    w_digit;
  logic          w_upper_zero;
  logic          w_lz;
  logic          w_show;
  logic [7:0]    w_an;
  logic [7:0]    w_sseg;

  // Active-low gfedcba pattern for one hex digit.
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == 3'd7);
  assign w_digit     = r_snap[{r_idx, 2'b00} +: 4];
  // Digit idx is a leading zero when it and every digit above it are zero.
  assign w_upper_zero = ((r_snap >> {r_idx, 2'b00}) == 32'd0);
  assign w_lz   = lz_blank && (r_idx != 3'd0) && w_upper_zero;
  assign w_show = (r_cnt >= CNT_BLANK) && dig_en[r_idx] && !w_lz;

  // Next anode/segment values for the current slot position.
  always_comb begin
    w_an   = 8'hFF;
    w_sseg = 8'hFF;
    if (w_show) begin
      w_an   = ~(8'b1 << r_idx);
      w_sseg = {~dp_in[r_idx], f_seg(w_digit)};
    end
  end

  // Slot counter, digit index and once-per-frame snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_idx    <= 3'd0;
      r_snap   <= 32'd0;
      r_primed <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (!r_primed || w_frame_end) begin
        r_snap <= {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
      end
      r_primed <= 1'b1;
    end
  end

  // Registered outputs; dark immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an         <= 8'hFF;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      an         <= w_an;
      sseg       <= w_sseg;
      frame_tick <= w_frame_end;
    end
  end

endmodule
